// File: rtl/pcie_lane_symbol_aligner_pkg.sv
// pcie_lane_symbol_aligner_pkg: K28.5 comma codes, aligner FSM states and offset width
package pcie_lane_symbol_aligner_pkg;
  localparam logic [9:0] COMMA_RDN = 10'h17C;
  localparam logic [9:0] COMMA_RDP = 10'h283;
  localparam int OFFSET_W = 4;
  typedef enum logic [1:0] {HUNT = 2'd0, VERIFY = 2'd1, LOCKED = 2'd2} alignState_t;
  function automatic logic isComma(input logic [9:0] sym);
    return sym == COMMA_RDN || sym == COMMA_RDP;
  endfunction
endpackage

// File: rtl/pcie_comma_scan.sv
// pcie_comma_scan: checks all ten bit offsets of a 20-bit window for K28.5, lowest offset wins
module pcie_comma_scan
  import pcie_lane_symbol_aligner_pkg::*;
(
  input  logic [19:0]         Window,
  output logic                CommaAny,
  output logic [OFFSET_W-1:0] CommaOffset,
  output logic [9:0]          Match
);
  for (genvar k = 0; k < 10; k++) begin : gCmp
    assign Match[k] = isComma(Window[k +: 10]);
  end
  assign CommaAny = |Match;
  // priority encoder: scanning downwards leaves the lowest matching offset
  always_comb begin
    CommaOffset = '0;
    for (int i = 9; i >= 0; i--) if (Match[i]) CommaOffset = OFFSET_W'(i);
  end
endmodule

// File: rtl/pcie_lane_symbol_aligner.sv
// pcie_lane_symbol_aligner: hunt/verify/locked comma aligner producing aligned 10b symbols; PCIE_ALIGN_STATS_EN enables the lock-loss counter
module pcie_lane_symbol_aligner
  import pcie_lane_symbol_aligner_pkg::*;
#(
  parameter int LOCK_COMMAS = 3,
  parameter int SLIP_COMMAS = 4,
  parameter int VERIFY_GAP  = 64
) (
  input  logic                Clk,
  input  logic                notReset,
  input  logic [9:0]          RawIn,
  input  logic                ElecIdle,
  output logic [9:0]          LinkOut,
  output logic                Synced,
  output logic                CommaDet,
  output logic [OFFSET_W-1:0] Offset,
  output logic [15:0]         ReAlignCount
);
  localparam logic [15:0] LOCK_N   = 16'(LOCK_COMMAS);
  localparam logic [15:0] SLIP_N   = 16'(SLIP_COMMAS);
  localparam logic [15:0] GAP_LAST = 16'(VERIFY_GAP - 1);
  alignState_t state, nextState;
  logic [9:0] prevRaw, nextSym, match;
  logic [19:0] history;
  logic commaAny, hitAtOffset;
  logic [OFFSET_W-1:0] commaOffset, nextOffset;
  logic [15:0] goodCnt, badCnt, gapCnt, nextGood, nextBad, nextGap, goodInc, badInc, gapInc;
  assign history = {RawIn, prevRaw};
  pcie_comma_scan uScan (
    .Window(history),
    .CommaAny(commaAny),
    .CommaOffset(commaOffset),
    .Match(match)
  );
  assign hitAtOffset = match[Offset];
  assign goodInc = &goodCnt ? goodCnt : goodCnt + 16'd1;
  assign badInc  = &badCnt ? badCnt : badCnt + 16'd1;
  assign gapInc  = &gapCnt ? gapCnt : gapCnt + 16'd1;
  assign nextSym = 10'(history >> nextOffset);
  // next-state logic; electrical idle overrides any comma seen in the same cycle
  always_comb begin
    nextState = state;
    nextOffset = Offset;
    nextGood = goodCnt;
    nextBad = badCnt;
    nextGap = gapCnt;
    if (ElecIdle) begin
      nextState = HUNT;
      nextGood = '0;
      nextBad = '0;
      nextGap = '0;
    end else if (state == HUNT) begin
      if (commaAny) begin
        nextState = VERIFY;
        nextOffset = commaOffset;
        nextGood = 16'd1;
        nextGap = '0;
      end
    end else if (state == VERIFY) begin
      if (hitAtOffset) begin
        nextGood = goodInc;
        nextGap = '0;
        if (goodInc >= LOCK_N) begin
          nextState = LOCKED;
          nextBad = '0;
        end
      end else if (commaAny) begin
        nextOffset = commaOffset;
        nextGood = 16'd1;
        nextGap = '0;
      end else begin
        nextGap = gapInc;
        if (gapCnt >= GAP_LAST) nextState = HUNT;
      end
    end else begin
      if (hitAtOffset) nextBad = '0;
      else if (commaAny) begin
        nextBad = badInc;
        if (badInc >= SLIP_N) nextState = HUNT;
      end
    end
  end
  // state, counters and the registered aligned output, using the new offset immediately
  always_ff @(posedge Clk or negedge notReset) begin
    if (!notReset) begin
      state <= HUNT;
      prevRaw <= '0;
      Offset <= '0;
      goodCnt <= '0;
      badCnt <= '0;
      gapCnt <= '0;
      LinkOut <= '0;
      CommaDet <= 1'b0;
      Synced <= 1'b0;
    end else begin
      state <= nextState;
      prevRaw <= RawIn;
      Offset <= nextOffset;
      goodCnt <= nextGood;
      badCnt <= nextBad;
      gapCnt <= nextGap;
      LinkOut <= nextSym;
      CommaDet <= isComma(nextSym);
      Synced <= nextState == LOCKED;
    end
  end
`ifdef PCIE_ALIGN_STATS_EN
  logic lockLost;
  assign lockLost = state == LOCKED && nextState == HUNT;
  // saturating count of every drop out of LOCKED, by slip or electrical idle
  always_ff @(posedge Clk or negedge notReset) begin
    if (!notReset) ReAlignCount <= '0;
    else if (lockLost && !(&ReAlignCount)) ReAlignCount <= ReAlignCount + 16'd1;
  end
`ifdef DEBUG
  // trace each lock loss
  always_ff @(posedge Clk) begin
    if (notReset && lockLost) $display("PCIE lane realign offset %0d", Offset);
  end
`endif
`else
  assign ReAlignCount = 16'h0000;
`endif
endmodule

// File: tb/tb_pcie_lane_symbol_aligner.sv
// tb_pcie_lane_symbol_aligner: directed bit-stream bench for the lane symbol aligner
module tb_pcie_lane_symbol_aligner;
  import pcie_lane_symbol_aligner_pkg::*;
  logic Clk = 1'b0;
  logic notReset = 1'b0;
  logic ElecIdle = 1'b0;
  logic [9:0] RawIn = '0;
  logic [9:0] LinkOut;
  logic Synced, CommaDet;
  logic [3:0] Offset;
  logic [15:0] ReAlignCount;
  int total = 0;
  int bad = 0;
  bit bq[$];
  bit fillBit = 1'b0;
  bit lowSeen = 1'b0;
  logic [9:0] sent[$];
  logic [9:0] dat [4] = '{10'h155, 10'h333, 10'h0CC, 10'h2AA};
`ifdef PCIE_ALIGN_STATS_EN
  localparam int STATS = 1;
`else
  localparam int STATS = 0;
`endif
  always #5 Clk = ~Clk;
  pcie_lane_symbol_aligner dut (
    .Clk(Clk),
    .notReset(notReset),
    .RawIn(RawIn),
    .ElecIdle(ElecIdle),
    .LinkOut(LinkOut),
    .Synced(Synced),
    .CommaDet(CommaDet),
    .Offset(Offset),
    .ReAlignCount(ReAlignCount)
  );
  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got %0h want %0h", tag, got, exp);
    end
  endtask
  task automatic step();
    logic [9:0] c;
    for (int i = 0; i < 10; i++) c[i] = bq.pop_front();
    RawIn = c;
    @(posedge Clk);
    #1;
    if (!Synced) lowSeen = 1'b1;
  endtask
  task automatic drain();
    while (bq.size() >= 10) step();
  endtask
  task automatic sendSym(input logic [9:0] s);
    for (int i = 0; i < 10; i++) bq.push_back(s[i]);
    sent.push_back(s);
    drain();
  endtask
  task automatic pushFill(input int n);
    for (int i = 0; i < n; i++) begin
      bq.push_back(fillBit);
      fillBit = !fillBit;
    end
    drain();
  endtask
  task automatic pair(input logic [9:0] c, input int d);
    sendSym(c);
    sendSym(dat[d % 4]);
  endtask
  task automatic doReset();
    notReset = 1'b0;
    RawIn = '0;
    ElecIdle = 1'b0;
    bq.delete();
    sent.delete();
    fillBit = 1'b0;
    repeat (2) @(posedge Clk);
    #1;
    chk("rst_link", LinkOut, 0);
    chk("rst_synced", Synced, 0);
    chk("rst_commadet", CommaDet, 0);
    chk("rst_offset", Offset, 0);
    chk("rst_realign", ReAlignCount, 0);
    notReset = 1'b1;
  endtask
  initial begin
    doReset();
    pushFill(3);
    for (int j = 0; j < 48; j++) begin
      sendSym(j % 16 == 2 ? COMMA_RDN : dat[j % 4]);
      if (j == 3) begin
        chk("first_offset", Offset, 3);
        chk("first_commadet", CommaDet, 1);
        chk("first_synced", Synced, 0);
      end
      if (j == 34) chk("pre_lock_synced", Synced, 0);
      if (j == 35) begin
        chk("lock_synced", Synced, 1);
        chk("lock_offset", Offset, 3);
      end
      if (j >= 3) chk($sformatf("link_%0d", j), LinkOut, sent[j - 1]);
    end
    lowSeen = 1'b0;
    pushFill(4);
    pair(COMMA_RDN, 1);
    pair(COMMA_RDN, 2);
    pushFill(6);
    pair(COMMA_RDN, 3);
    chk("tol_offset", Offset, 3);
    pushFill(4);
    for (int i = 0; i < 3; i++) pair(COMMA_RDN, i);
    pushFill(6);
    pair(COMMA_RDN, 0);
    chk("tol_sync_held", lowSeen, 0);
    pushFill(4);
    for (int i = 0; i < 3; i++) pair(COMMA_RDN, i);
    chk("slip3_synced", Synced, 1);
    pair(COMMA_RDN, 3);
    chk("slip4_synced", Synced, 0);
    chk("slip_offset", Offset, 3);
    chk("slip_realign", ReAlignCount, STATS);
    pair(COMMA_RDN, 0);
    chk("relock1_offset", Offset, 7);
    chk("relock1_synced", Synced, 0);
    pair(COMMA_RDN, 1);
    pair(COMMA_RDN, 2);
    chk("relock_synced", Synced, 1);
    chk("relock_offset", Offset, 7);
    chk("relock_link", LinkOut, COMMA_RDN);
    chk("relock_commadet", CommaDet, 1);
    sendSym(COMMA_RDN);
    ElecIdle = 1'b1;
    sendSym(dat[0]);
    ElecIdle = 1'b0;
    chk("idle_synced", Synced, 0);
    chk("idle_offset", Offset, 7);
    chk("idle_link", LinkOut, COMMA_RDN);
    chk("idle_commadet", CommaDet, 1);
    chk("idle_realign", ReAlignCount, 2 * STATS);
    pair(COMMA_RDN, 1);
    chk("gap_verify_synced", Synced, 0);
    for (int i = 0; i < 64; i++) sendSym(dat[i % 4]);
    chk("gap_synced", Synced, 0);
    pair(COMMA_RDN, 2);
    pair(COMMA_RDN, 3);
    chk("gap_hunt_two", Synced, 0);
    pair(COMMA_RDN, 0);
    chk("gap_hunt_three", Synced, 1);
    doReset();
    sendSym(dat[0]);
    sendSym(COMMA_RDN);
    sendSym(dat[1]);
    chk("alt_rdn_det", CommaDet, 1);
    chk("alt_rdn_link", LinkOut, COMMA_RDN);
    chk("alt_offset", Offset, 0);
    sendSym(COMMA_RDP);
    chk("alt_data_det", CommaDet, 0);
    chk("alt_data_link", LinkOut, dat[1]);
    sendSym(dat[2]);
    chk("alt_rdp_det", CommaDet, 1);
    chk("alt_rdp_link", LinkOut, COMMA_RDP);
    chk("alt_pre_synced", Synced, 0);
    pair(COMMA_RDN, 3);
    chk("alt_lock_det", CommaDet, 1);
    chk("alt_lock_synced", Synced, 1);
    pair(COMMA_RDP, 0);
    chk("alt_rdp2_det", CommaDet, 1);
    chk("alt_rdp2_link", LinkOut, COMMA_RDP);
    chk("alt_rdp2_synced", Synced, 1);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
